// File: rtl/avalon_timer_array_pkg.sv
// Shared definitions for the Avalon-MM timer array: register offsets,
// CTRL bit positions and the per-channel state encoding.
package avalon_timer_pkg;

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_LOAD   = 2'd1;
  localparam logic [1:0] REG_COUNT  = 2'd2;
  localparam logic [1:0] REG_STATUS = 2'd3;

  localparam int CTRL_ENABLE_BIT   = 0;
  localparam int CTRL_PERIODIC_BIT = 1;
  localparam int CTRL_IRQ_EN_BIT   = 2;
  localparam int CTRL_PRESC_LSB    = 16;

  localparam int STATUS_EXPIRED_BIT = 0;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } timer_state_e;

endpackage

// File: rtl/avalon_timer_array_if.sv
// Avalon-MM slave bus plus interrupt outputs of the timer array.
interface avalon_timer_array_if #(
  parameter int NUM_TIMERS = 4
);

  logic                  read_n;
  logic                  write_n;
  logic [31:0]           address;
  logic [31:0]           writeData;
  logic [31:0]           readData;
  logic [NUM_TIMERS-1:0] irq;
  logic                  irq_any;

  modport master (
    output read_n, write_n, address, writeData,
    input  readData, irq, irq_any
  );

  modport slave (
    input  read_n, write_n, address, writeData,
    output readData, irq, irq_any
  );

endinterface

// File: rtl/avalon_timer_array_channel.sv
// One down-counting timer channel: CTRL/LOAD/COUNT/STATUS registers,
// prescaler, IDLE/RUN state machine and sticky expiry flag.
module timer_channel
  import avalon_timer_pkg::*;
#(
  parameter int CNT_WIDTH   = 32,
  parameter int PRESC_WIDTH = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ctrl_we,
  input  logic        load_we,
  input  logic        status_we,
  input  logic [31:0] wdata,
  output logic [31:0] ctrl_rd,
  output logic [31:0] load_rd,
  output logic [31:0] count_rd,
  output logic [31:0] status_rd,
  output logic        irq
);

  localparam logic [CNT_WIDTH-1:0]   CNT_ONE   = CNT_WIDTH'(1);
  localparam logic [PRESC_WIDTH-1:0] PRESC_ONE = PRESC_WIDTH'(1);

  timer_state_e           state;
  logic                   enable;
  logic                   periodic;
  logic                   irq_en;
  logic                   expired;
  logic [PRESC_WIDTH-1:0] prescale;
  logic [PRESC_WIDTH-1:0] presc_cnt;
  logic [CNT_WIDTH-1:0]   load;
  logic [CNT_WIDTH-1:0]   count;
  logic                   tick;
  logic                   expire;
  logic                   unused_wdata;

  // >= keeps the prescaler from running away if prescale shrinks mid-run
  assign tick         = (state == RUN) && (presc_cnt >= prescale);
  assign expire       = tick && (count == '0);
  assign irq          = expired & irq_en;
  assign unused_wdata = ^wdata;

  // Later assignments override earlier ones: bus writes beat the tick,
  // and setting the expiry flag beats the W1C clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      enable    <= 1'b0;
      periodic  <= 1'b0;
      irq_en    <= 1'b0;
      expired   <= 1'b0;
      prescale  <= '0;
      presc_cnt <= '0;
      load      <= '0;
      count     <= '0;
    end else begin
      if (state == RUN) begin
        if (tick) begin
          presc_cnt <= '0;
          if (count != '0) begin
            count <= count - CNT_ONE;
          end else if (periodic) begin
            count <= load;
          end else begin
            enable <= 1'b0;
            state  <= IDLE;
          end
        end else begin
          presc_cnt <= presc_cnt + PRESC_ONE;
        end
      end

      if (ctrl_we) begin
        enable   <= wdata[CTRL_ENABLE_BIT];
        periodic <= wdata[CTRL_PERIODIC_BIT];
        irq_en   <= wdata[CTRL_IRQ_EN_BIT];
        prescale <= wdata[CTRL_PRESC_LSB +: PRESC_WIDTH];
        if (!wdata[CTRL_ENABLE_BIT]) begin
          state <= IDLE;
        end else begin
          state <= RUN;
          if (!enable) begin
            count     <= load;
            presc_cnt <= '0;
          end
        end
      end

      if (load_we) begin
        load      <= wdata[CNT_WIDTH-1:0];
        count     <= wdata[CNT_WIDTH-1:0];
        presc_cnt <= '0;
      end

      if (status_we && wdata[STATUS_EXPIRED_BIT]) begin
        expired <= 1'b0;
      end
      if (expire) begin
        expired <= 1'b1;
      end
    end
  end

  always_comb begin
    ctrl_rd                                    = '0;
    ctrl_rd[CTRL_ENABLE_BIT]                   = enable;
    ctrl_rd[CTRL_PERIODIC_BIT]                 = periodic;
    ctrl_rd[CTRL_IRQ_EN_BIT]                   = irq_en;
    ctrl_rd[CTRL_PRESC_LSB +: PRESC_WIDTH]     = prescale;
    load_rd                                    = '0;
    load_rd[CNT_WIDTH-1:0]                     = load;
    count_rd                                   = '0;
    count_rd[CNT_WIDTH-1:0]                    = count;
    status_rd                                  = '0;
    status_rd[STATUS_EXPIRED_BIT]              = expired;
  end

endmodule

// File: rtl/avalon_timer_array.sv
// Avalon-MM timer array top: address decode, per-channel write enables,
// registered read mux and the combined interrupt line.
module avalon_timer_array
  import avalon_timer_pkg::*;
#(
  parameter int NUM_TIMERS  = 4,
  parameter int CNT_WIDTH   = 32,
  parameter int PRESC_WIDTH = 16
) (
  input logic                 clk,
  input logic                 rst_n,
  avalon_timer_array_if.slave bus
);

  logic [3:0]            ch_sel;
  logic [1:0]            reg_sel;
  logic                  ch_valid;
  logic                  wr;
  logic [31:0]           rd_mux;
  logic [NUM_TIMERS-1:0] irq_vec;
  logic                  unused_addr;

  logic [31:0] ctrl_rd   [NUM_TIMERS];
  logic [31:0] load_rd   [NUM_TIMERS];
  logic [31:0] count_rd  [NUM_TIMERS];
  logic [31:0] status_rd [NUM_TIMERS];

  assign ch_sel      = bus.address[7:4];
  assign reg_sel     = bus.address[3:2];
  assign ch_valid    = {1'b0, ch_sel} < 5'(NUM_TIMERS);
  assign wr          = !bus.write_n && ch_valid;
  assign unused_addr = ^{bus.address[31:8], bus.address[1:0]};

  for (genvar i = 0; i < NUM_TIMERS; i++) begin : g_ch
    logic sel;
    assign sel = wr && (ch_sel == 4'(i));

    timer_channel #(
      .CNT_WIDTH   (CNT_WIDTH),
      .PRESC_WIDTH (PRESC_WIDTH)
    ) u_channel (
      .clk       (clk),
      .rst_n     (rst_n),
      .ctrl_we   (sel && (reg_sel == REG_CTRL)),
      .load_we   (sel && (reg_sel == REG_LOAD)),
      .status_we (sel && (reg_sel == REG_STATUS)),
      .wdata     (bus.writeData),
      .ctrl_rd   (ctrl_rd[i]),
      .load_rd   (load_rd[i]),
      .count_rd  (count_rd[i]),
      .status_rd (status_rd[i]),
      .irq       (irq_vec[i])
    );
  end

  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < NUM_TIMERS; i++) begin
      if (ch_valid && (ch_sel == 4'(i))) begin
        case (reg_sel)
          REG_CTRL:   rd_mux = ctrl_rd[i];
          REG_LOAD:   rd_mux = load_rd[i];
          REG_COUNT:  rd_mux = count_rd[i];
          REG_STATUS: rd_mux = status_rd[i];
          default:    rd_mux = '0;
        endcase
      end
    end
  end

  // Sampled at the same edge as any concurrent write, so a combined
  // read+write returns the pre-write value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.readData <= '0;
    end else begin
      bus.readData <= !bus.read_n ? rd_mux : '0;
    end
  end

  assign bus.irq     = irq_vec;
  assign bus.irq_any = |irq_vec;

endmodule

// File: tb/tb_avalon_timer_array.sv
// Directed self-checking bench for avalon_timer_array with hand-computed
// expectations for periodic, one-shot, collision, decode and reset cases.
module tb_avalon_timer_array;
  import avalon_timer_pkg::*;

  localparam int NUM_TIMERS = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  int          total = 0;
  int          bad = 0;
  logic [31:0] rdata;

  avalon_timer_array_if #(.NUM_TIMERS(NUM_TIMERS)) bus ();

  avalon_timer_array #(
    .NUM_TIMERS  (NUM_TIMERS),
    .CNT_WIDTH   (32),
    .PRESC_WIDTH (16)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] regAddr(input int ch, input logic [1:0] r);
    return {24'd0, 4'(ch), r, 2'b00};
  endfunction

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic nextCycles(input int n);
    repeat (n) nextCycle();
  endtask

  // One bus cycle; returns 1 ns after the edge that captured it
  task automatic applyStimulus(input logic rd, input logic wr,
                               input logic [31:0] addr, input logic [31:0] data);
    bus.read_n    = !rd;
    bus.write_n   = !wr;
    bus.address   = addr;
    bus.writeData = data;
    nextCycle();
    bus.read_n    = 1'b1;
    bus.write_n   = 1'b1;
  endtask

  task automatic busWrite(input int ch, input logic [1:0] r, input logic [31:0] data);
    applyStimulus(1'b0, 1'b1, regAddr(ch, r), data);
  endtask

  task automatic busRead(input int ch, input logic [1:0] r, output logic [31:0] data);
    applyStimulus(1'b1, 1'b0, regAddr(ch, r), 32'd0);
    data = bus.readData;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  task automatic readCheck(input string tag, input int ch, input logic [1:0] r,
                           input logic [31:0] expected);
    logic [31:0] d;
    busRead(ch, r, d);
    checkOutput(tag, d, expected);
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.read_n    = 1'b1;
    bus.write_n   = 1'b1;
    bus.address   = '0;
    bus.writeData = '0;
    nextCycles(3);
    checkOutput("reset_readData", bus.readData, 32'd0);
    checkOutput("reset_irq", 32'(bus.irq), 32'd0);
    checkOutput("reset_irq_any", 32'(bus.irq_any), 32'd0);
    rst_n = 1'b1;
    nextCycle();
    readCheck("reset_ctrl0", 0, REG_CTRL, 32'd0);
    readCheck("reset_count0", 0, REG_COUNT, 32'd0);

    $display("[TB] periodic expiry on ch0");
    busWrite(0, REG_LOAD, 32'd3);
    busWrite(0, REG_CTRL, 32'h0000_0007);
    nextCycles(3);
    checkOutput("per_before_expiry", 32'(bus.irq[0]), 32'd0);
    nextCycle();
    checkOutput("per_first_expiry", 32'(bus.irq[0]), 32'd1);
    checkOutput("per_irq_any", 32'(bus.irq_any), 32'd1);
    busWrite(0, REG_STATUS, 32'd1);
    checkOutput("per_w1c", 32'(bus.irq[0]), 32'd0);
    nextCycles(2);
    checkOutput("per_gap", 32'(bus.irq[0]), 32'd0);
    nextCycle();
    checkOutput("per_second_expiry", 32'(bus.irq[0]), 32'd1);

    $display("[TB] set/clear collision on ch0");
    busWrite(0, REG_STATUS, 32'd1);
    checkOutput("coll_pre_clear", 32'(bus.irq[0]), 32'd0);
    nextCycles(2);
    checkOutput("coll_pre_edge", 32'(bus.irq[0]), 32'd0);
    busWrite(0, REG_STATUS, 32'd1);
    checkOutput("coll_set_wins", 32'(bus.irq[0]), 32'd1);
    checkOutput("coll_irq_any", 32'(bus.irq_any), 32'd1);
    busWrite(0, REG_CTRL, 32'd0);
    busWrite(0, REG_STATUS, 32'd1);
    checkOutput("ch0_quiet", 32'(bus.irq_any), 32'd0);

    $display("[TB] one-shot on ch1");
    busWrite(1, REG_LOAD, 32'd5);
    busWrite(1, REG_CTRL, 32'h0001_0005);
    nextCycles(11);
    checkOutput("oneshot_before", 32'(bus.irq[1]), 32'd0);
    nextCycle();
    checkOutput("oneshot_expired", 32'(bus.irq[1]), 32'd1);
    readCheck("oneshot_count", 1, REG_COUNT, 32'd0);
    readCheck("oneshot_ctrl", 1, REG_CTRL, 32'h0001_0004);
    readCheck("oneshot_status", 1, REG_STATUS, 32'd1);

    $display("[TB] read latency on ch2");
    busWrite(2, REG_LOAD, 32'd100);
    busWrite(2, REG_CTRL, 32'h0000_0001);
    busRead(2, REG_COUNT, rdata);
    checkOutput("lat_valid", rdata, 32'd100);
    nextCycle();
    checkOutput("lat_cleared", bus.readData, 32'd0);

    $display("[TB] simultaneous read and write on ch3");
    busWrite(3, REG_LOAD, 32'h11);
    applyStimulus(1'b1, 1'b1, regAddr(3, REG_LOAD), 32'h22);
    checkOutput("rw_prewrite", bus.readData, 32'h11);
    readCheck("rw_load_new", 3, REG_LOAD, 32'h22);
    readCheck("rw_count_follows", 3, REG_COUNT, 32'h22);
    busWrite(3, REG_COUNT, 32'h99);
    readCheck("count_ro", 3, REG_COUNT, 32'h22);

    $display("[TB] periodic LOAD=0 on ch3");
    busWrite(3, REG_LOAD, 32'd0);
    busWrite(3, REG_CTRL, 32'h0000_0003);
    nextCycle();
    readCheck("load0_status", 3, REG_STATUS, 32'd1);
    readCheck("load0_count", 3, REG_COUNT, 32'd0);
    checkOutput("load0_masked", 32'(bus.irq[3]), 32'd0);
    busWrite(3, REG_CTRL, 32'd0);

    $display("[TB] out-of-range channel 5");
    busWrite(5, REG_LOAD, 32'h0000_DEAD);
    busWrite(5, REG_CTRL, 32'h0000_0007);
    readCheck("oor_load", 5, REG_LOAD, 32'd0);
    readCheck("oor_ctrl", 5, REG_CTRL, 32'd0);
    readCheck("oor_ch1_load", 1, REG_LOAD, 32'd5);
    readCheck("oor_ch1_ctrl", 1, REG_CTRL, 32'h0001_0004);
    checkOutput("oor_irq", 32'(bus.irq), 32'h2);

    $display("[TB] reset mid-count on ch0");
    busWrite(0, REG_LOAD, 32'd50);
    busWrite(0, REG_CTRL, 32'h0000_0007);
    nextCycles(5);
    busRead(0, REG_COUNT, rdata);
    checkOutput("mid_count", rdata, 32'd45);
    #3;
    rst_n = 1'b0;
    #1;
    checkOutput("rst_readData", bus.readData, 32'd0);
    checkOutput("rst_irq", 32'(bus.irq), 32'd0);
    checkOutput("rst_irq_any", 32'(bus.irq_any), 32'd0);
    #1;
    rst_n = 1'b1;
    nextCycles(4);
    readCheck("post_rst_count", 0, REG_COUNT, 32'd0);
    readCheck("post_rst_ctrl", 0, REG_CTRL, 32'd0);
    readCheck("post_rst_status1", 1, REG_STATUS, 32'd0);
    checkOutput("post_rst_irq", 32'(bus.irq), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/avalon_timer_array.md
# avalon_timer_array

Parametrised array of independent down-counting timers behind one Avalon-MM slave port. Each channel has a programmable reload value, a prescaler, one-shot or periodic mode, and a sticky expiry flag with a maskable interrupt. The block sits on the peripheral bus next to the other memory-mapped peripherals. It drives a per-channel interrupt vector plus an OR-combined interrupt line toward the processor.

## Interface

**Parameters**
- `NUM_TIMERS`, 4: number of channels, 1..16.
- `CNT_WIDTH`, 32: counter and reload width, 8..32.
- `PRESC_WIDTH`, 16: prescaler width, ≤16.

**Ports**
- `clk`  in  1  single clock for the whole block.
- `rst_n`  in  1  asynchronous, active-low reset.
- `read_n`  in  1  active-low read strobe, one cycle per access.
- `write_n`  in  1  active-low write strobe, one cycle per access.
- `address`  in  32  byte address.
  - `[3:2]` selects the register.
  - `[7:4]` selects the channel.
  - All other bits are ignored.
- `writeData`  in  32  write data.
- `readData`  out  32  registered read data.
- `irq`  out  NUM_TIMERS  per-channel interrupt, equal to `status.expired & ctrl.irq_en`.
- `irq_any`  out  1  OR of `irq`.

## Operation

**Register map (per channel)**
- 0x0 CTRL, RW.
  - bit0 `enable`.
  - bit1 `periodic` (0 = one-shot).
  - bit2 `irq_en`.
  - `[16+PRESC_WIDTH-1:16]` `prescale`.
  - Other bits read 0.
- 0x4 LOAD, RW. Reload value, zero-extended to 32 bits on read.
- 0x8 COUNT, RO. Current count. Writes are ignored.
- 0xC STATUS. bit0 `expired`, write-1-to-clear.

**Bus access**
- A channel index ≥ NUM_TIMERS reads 0, and writes to it are ignored.
- If `read_n` and `write_n` are both low, the write is performed and the read returns the pre-write value.

**Prescaler and ticks**
- The prescaler counts 0..`prescale`.
- A tick is issued on the cycle it equals `prescale`, after which it returns to 0.
- With `prescale` = 0, a tick occurs every cycle while enabled.

**State machine (per channel): IDLE, RUN**
- IDLE → RUN: when CTRL is written with `enable` 0→1. On that transition:
  - COUNT loads from LOAD.
  - The prescaler clears.
- RUN, on a tick with COUNT ≠ 0: decrement COUNT.
- RUN, on a tick with COUNT = 0:
  - Set `expired`.
  - If periodic: reload COUNT from LOAD and stay in RUN.
  - If one-shot: hold COUNT at 0, clear `enable`, go to IDLE.
- RUN → IDLE: when CTRL is written with `enable` = 0. COUNT freezes.
- Writing LOAD in any state also writes COUNT and clears the prescaler.

**Width rules and boundary conditions**
- LOAD = 0 in periodic mode: expires on every tick.
- Period = (LOAD+1)·(prescale+1) cycles.
- COUNT never wraps below 0.
- An expiry and a STATUS W1C in the same cycle: set wins, and `expired` stays 1.
- An expiry and a LOAD write in the same cycle: the LOAD write wins the COUNT value, and `expired` is still set.

## Timing

**Reset values**
- All registers, the prescaler, `readData`, `irq` and `irq_any` are 0.
- Every state machine is in IDLE.
- Reset asserted mid-count returns all of the above to reset values immediately. Counting does not resume after release.

**Writes**
- A write takes effect at the clock edge where `write_n` = 0.
- The new value is visible on the next cycle.

**Reads**
- `readData` is valid exactly 1 cycle after the `read_n` = 0 cycle.
- `readData` is 0 in every cycle not following a read.

**Counting**
- The first tick after enable occurs `prescale`+1 cycles after the enabling write edge.

**Interrupts**
- `expired` and `irq` rise on the cycle after the expiring tick edge. Both are registered.
- `irq_any` is combinational from the registered `irq` flags.

## Structure

- Package `avalon_timer_pkg` holds:
  - register offsets `REG_CTRL`, `REG_LOAD`, `REG_COUNT`, `REG_STATUS`;
  - CTRL bit positions;
  - the `timer_state_e` enum (IDLE, RUN).
- Sub-module `timer_channel`, parametrised by CNT_WIDTH and PRESC_WIDTH.
  - Contains the registers, prescaler, FSM and flag for one channel.
  - Instantiated NUM_TIMERS times in a generate loop.
- The top level contains only address decode, the write enables, the registered read mux and the interrupt OR.

## Test plan

- **Periodic expiry:** ch0 LOAD=3, CTRL=0x7 (prescale 0) → `irq[0]` rises after 4 cycles. W1C STATUS clears it. It re-asserts every 4 cycles.
- **One-shot:** ch1 LOAD=5, CTRL=0x5, prescale=1 → `expired` sets after 12 cycles. COUNT reads 0. CTRL reads 0x00010004 (`enable` cleared).
- **Set/clear collision:** a STATUS W1C on the expiring cycle → `expired` remains 1, and `irq_any` remains 1.
- **Read latency:** read COUNT while counting → `readData` is valid on the next cycle only, and is 0 on the cycle after that.
- **Out-of-range channel:** with NUM_TIMERS=4, write then read channel 5 → returns 0, and no channel state changes.
- **Reset mid-operation:** pull `rst_n` low mid-count (async, between edges) → COUNT, CTRL, `irq` and `readData` are 0 immediately. After release, COUNT stays 0.
